// File: rtl/fwd_hazard_ctrl.sv
// Purpose: operand-forwarding selects and load-use stall for a 5-stage RISC-V pipeline.
// Latency: stall_o is combinational from the ID inputs; ForwardA_o/ForwardB_o are registered, 1 cycle after ID.
// Backpressure: stall_o holds PC and IF/ID for one cycle per load-use pair and injects a bubble into EX.
module fwd_hazard_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_use_rs1_i,
  input  logic        id_use_rs2_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_regwrite_i,
  input  logic        id_memread_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [1:0]  ForwardA_o,
  output logic [1:0]  ForwardB_o,
  output logic [15:0] stall_cnt_o
);

  localparam logic [1:0] FWD_IDEX  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // Shadow slots keep only the producer-side fields that the hazard and
  // forwarding decisions look at. The consumer fields of the EX instruction
  // and the whole WB slot influence no output, so they are not stored.
  logic       ex_v;
  logic       ex_rw;
  logic       ex_mr;
  logic [4:0] ex_rd;
  logic       mem_v;
  logic       mem_rw;
  logic [4:0] mem_rd;

  logic        hazard;
  logic        in_v;
  logic [1:0]  fwd_a_nxt;
  logic [1:0]  fwd_b_nxt;
  logic [15:0] stall_cnt;

  // A slot produces register r only if it is live, writes, and r is not x0.
  function automatic logic writer_match(input logic v, input logic rw,
                                        input logic [4:0] rd, input logic [4:0] r);
    return v & rw & (rd != 5'd0) & (rd == r);
  endfunction

  // Youngest producer wins: the instruction now in EX (next in MEM) beats the one now in MEM.
  function automatic logic [1:0] pick_fwd(input logic incoming_v, input logic use_r,
                                          input logic [4:0] r,
                                          input logic ev, input logic erw, input logic [4:0] erd,
                                          input logic mv, input logic mrw, input logic [4:0] mrd);
    logic [1:0] sel;
    sel = FWD_IDEX;
    if (incoming_v && use_r) begin
      if (writer_match(ev, erw, erd, r))      sel = FWD_EXMEM;
      else if (writer_match(mv, mrw, mrd, r)) sel = FWD_MEMWB;
    end
    return sel;
  endfunction

  // Load-use detection against the load sitting in EX; a flushed ID op never stalls.
  always_comb begin
    hazard = id_valid_i & ex_v & ex_mr & (ex_rd != 5'd0) &
             ((id_use_rs1_i & (ex_rd == id_rs1_i)) |
              (id_use_rs2_i & (ex_rd == id_rs2_i)));
    stall_o = hazard & ~flush_i;
    in_v    = id_valid_i & ~stall_o & ~flush_i;
  end

  // Forward selects for the instruction about to enter EX.
  always_comb begin
    fwd_a_nxt = pick_fwd(in_v, id_use_rs1_i, id_rs1_i,
                         ex_v, ex_rw, ex_rd, mem_v, mem_rw, mem_rd);
    fwd_b_nxt = pick_fwd(in_v, id_use_rs2_i, id_rs2_i,
                         ex_v, ex_rw, ex_rd, mem_v, mem_rw, mem_rd);
  end

  // Advance the shadow pipeline; a bubble carries no control bits.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_v   <= 1'b0;
      ex_rw  <= 1'b0;
      ex_mr  <= 1'b0;
      ex_rd  <= 5'd0;
      mem_v  <= 1'b0;
      mem_rw <= 1'b0;
      mem_rd <= 5'd0;
    end else begin
      mem_v  <= ex_v;
      mem_rw <= ex_rw;
      mem_rd <= ex_rd;
      ex_v   <= in_v;
      ex_rw  <= in_v & id_regwrite_i;
      ex_mr  <= in_v & id_memread_i;
      ex_rd  <= id_rd_i;
    end
  end

  // Register the selects so they line up with the ID/EX register outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ForwardA_o <= FWD_IDEX;
      ForwardB_o <= FWD_IDEX;
    end else begin
      ForwardA_o <= fwd_a_nxt;
      ForwardB_o <= fwd_b_nxt;
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt <= 16'd0;
    end else if (stall_o && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Pipeline hazard controller that drives the select inputs of the two ALU-operand forwarding muxes and generates load-use stalls for the 5-stage RISC-V core. It tracks the destination register and control bits of every instruction in EX, MEM and WB in its own shadow pipeline. From that it produces registered ForwardA/ForwardB codes for the instruction entering EX, and a stall request for the ID stage. It sits beside the ID/EX pipeline register and is clocked with it.

## Interface
- No parameters; register index width fixed at 5, select width fixed at 2.
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-low reset; sampled on the rising edge of clk_i.
- id_valid_i  in  1  instruction in ID is real, not a bubble.
- id_rs1_i, id_rs2_i  in  5 each  source register indices of the ID instruction.
- id_use_rs1_i, id_use_rs2_i  in  1 each  ID instruction actually reads rs1/rs2.
- id_rd_i  in  5  destination index of the ID instruction.
- id_regwrite_i  in  1  ID instruction writes the register file.
- id_memread_i  in  1  ID instruction is a load.
- flush_i  in  1  squash the ID instruction (taken branch); it must not enter EX.
- stall_o  out  1  hold PC and IF/ID; ID/EX receives a bubble.
- ForwardA_o, ForwardB_o  out  2 each  mux selects for the instruction now in EX: 2'b00 = ID/EX register value, 2'b10 = EX/MEM result, 2'b01 = MEM/WB write-back value; 2'b11 never driven.
- stall_cnt_o  out  16  saturating count of cycles with stall_o high.

## Operation
- Shadow slots: EX {v, rs1, rs2, use1, use2, rd, rw, mr}, MEM {v, rd, rw, mr}, WB {v, rd, rw}.
- Each edge (rst_i high): WB <= MEM; MEM <= EX; EX <= ID fields with v = id_valid_i & ~stall_o & ~flush_i. When v = 0, all EX control bits are 0.
- "Writer X matches r": X.v & X.rw & X.rd != 0 & X.rd == r. Register x0 never matches.
- Hazard (combinational): id_valid_i & EX.v & EX.mr & EX.rd != 0 & ((id_use_rs1_i & EX.rd == id_rs1_i) | (id_use_rs2_i & EX.rd == id_rs2_i)).
- stall_o = hazard & ~flush_i. A flushed instruction never stalls.
- Forward select, computed at the edge that loads the EX slot. For source r with use bit set and incoming v = 1:
  - If the current EX slot (next MEM) matches r: 2'b10.
  - Else if the current MEM slot (next WB) matches r: 2'b01.
  - Else: 2'b00.
  - The EX/MEM match has priority over MEM/WB (youngest producer wins).
  - If the use bit is 0 or the incoming v = 0, the select is 2'b00.
- A load in MEM matched by the EX consumer cannot occur, because the stall guarantees at least one bubble. If it occurs anyway, the rule still yields 2'b10 and no special case is added.
- stall_cnt_o increments by 1 on every edge where stall_o = 1, and holds at 16'hFFFF.

## Timing
- Reset (rst_i low at an edge): all slot valid bits 0, ForwardA_o = ForwardB_o = 2'b00, stall_cnt_o = 0. stall_o is therefore 0 in the cycle after reset.
- Reset asserted mid-stream discards all tracked instructions. No forwarding is produced for instructions that were in flight.
- stall_o: combinational, same cycle as the ID inputs. It is high for exactly one cycle per load-use pair: after the bubble, the load moves to MEM and the hazard term clears.
- ForwardA_o/ForwardB_o: registered, valid for the whole cycle the instruction occupies EX, and aligned with the ID/EX register outputs.
- Latency ID→forward select: 1 cycle.
- Simultaneous flush_i and hazard: stall_o = 0, the EX slot gets a bubble, and stall_cnt_o is unchanged.

## Test plan
- Reset: hold rst_i = 0 for 2 cycles with random inputs -> stall_o = 0, forwards = 00, stall_cnt_o = 0 at the first edge after release.
- Back-to-back ALU: add x5 ← …, then add x6, x5, x5 -> second instruction in EX shows ForwardA = ForwardB = 2'b10, stall_o never asserted.
- Distance 2: add x5; nop; sub x7, x1, x5 -> ForwardA = 00, ForwardB = 01. Same test with an intervening write to x5 -> ForwardB = 10 (priority).
- Load-use: lw x8; add x9, x8, x2 -> stall_o = 1 for exactly one cycle, bubble enters EX, add in EX gets ForwardA = 01, stall_cnt_o = 1.
- x0 and unused sources: lw x0; add x1, x0, x0 -> no stall, forwards 00. lw x3; jal (use1 = use2 = 0, rs1 = 3) -> no stall.
- Flush plus counter: flush_i = 1 alongside a load-use hazard -> stall_o = 0, no forwarding to the squashed op. Then 70000 forced hazard cycles -> stall_cnt_o saturates at 16'hFFFF.
